// File: rtl/vx_local_mem_pkg.sv
// Shared widths and types for the local memory controller and its response FIFO.
package vx_local_mem_pkg;

  localparam int unsigned VX_MEM_DATA_WIDTH   = 512;
  localparam int unsigned VX_MEM_BYTEEN_WIDTH = VX_MEM_DATA_WIDTH / 8;
  localparam int unsigned VX_MEM_ADDR_WIDTH   = 26;
  localparam int unsigned VX_MEM_TAG_WIDTH    = 8;
  localparam int unsigned PERF_CNT_WIDTH      = 32;

  typedef struct packed {
    logic [VX_MEM_DATA_WIDTH-1:0] data;
    logic [VX_MEM_TAG_WIDTH-1:0]  tag;
  } rsp_entry_t;

  function automatic int unsigned idx_width(int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/vx_local_mem_rsp_fifo.sv
// First-word-fall-through response FIFO; head is driven straight from storage.
module vx_local_mem_rsp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  entry_t                       push_data,
  input  logic                         pop,
  output entry_t                       head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == CntW'(DEPTH));
  assign count  = count_q;
  assign head   = mem_q[rd_ptr_q];
  assign do_pop = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push && !do_pop) count_q <= count_q + 1'b1;
      else if (!push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  // Upstream credits must make overflow impossible.
  no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/vx_local_mem_ctrl.sv
// Local memory controller terminating the Vortex memory port with credit-limited read responses.
// Optional perf counters are enabled by defining VX_LOCAL_MEM_PERF_EN.
module vx_local_mem_ctrl
  import vx_local_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mem_req_valid,
  input  logic                           mem_req_rw,
  input  logic [VX_MEM_BYTEEN_WIDTH-1:0] mem_req_byteen,
  input  logic [VX_MEM_ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [VX_MEM_DATA_WIDTH-1:0]   mem_req_data,
  input  logic [VX_MEM_TAG_WIDTH-1:0]    mem_req_tag,
  output logic                           mem_req_ready,
  output logic                           mem_rsp_valid,
  output logic [VX_MEM_DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [VX_MEM_TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                           mem_rsp_ready,
`ifdef VX_LOCAL_MEM_PERF_EN
  output logic [PERF_CNT_WIDTH-1:0]      perf_reads,
  output logic [PERF_CNT_WIDTH-1:0]      perf_writes,
  output logic [PERF_CNT_WIDTH-1:0]      perf_stall_cycles,
`endif
  output logic                           tb_addr_out_of_bounds
);

  localparam int unsigned IdxW = idx_width(MEM_WORDS);
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  logic [VX_MEM_DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  logic [IdxW-1:0]  idx;
  logic             oob, req_fire, rd_fire, wr_fire, rsp_pop;
  logic [CntW-1:0]  outstanding_q, outstanding_d;
  logic [LATENCY-1:0] pipe_valid_q;
  rsp_entry_t       pipe_q [LATENCY];
  rsp_entry_t       rd_entry, rsp_head;
  logic             rsp_empty;
  logic [CntW-1:0]  rsp_count;
  logic             oob_q;

  assign idx = mem_req_addr[IdxW-1:0];
  assign oob = (mem_req_addr >> IdxW) != '0;

  assign mem_req_ready = !reset && (outstanding_q < CntW'(RSP_DEPTH));
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rd_fire       = req_fire && !mem_req_rw;
  assign wr_fire       = req_fire && mem_req_rw;
  assign rsp_pop       = mem_rsp_valid && mem_rsp_ready;

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_fire && !oob) begin
      for (int i = 0; i < VX_MEM_BYTEEN_WIDTH; i++) begin
        if (mem_req_byteen[i]) mem_q[idx][i*8 +: 8] <= mem_req_data[i*8 +: 8];
      end
    end
  end

  always_comb begin
    rd_entry      = '0;
    rd_entry.data = oob ? '0 : mem_q[idx];
    rd_entry.tag  = mem_req_tag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_valid_q[0] <= rd_fire;
      pipe_q[0]       <= rd_entry;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_q[i]       <= pipe_q[i-1];
      end
    end
  end

  vx_local_mem_rsp_fifo #(
    .DEPTH   (RSP_DEPTH),
    .entry_t (rsp_entry_t)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pipe_valid_q[LATENCY-1]),
    .push_data (pipe_q[LATENCY-1]),
    .pop       (rsp_pop),
    .head      (rsp_head),
    .empty     (rsp_empty),
    .count     (rsp_count)
  );

  assign mem_rsp_valid = !rsp_empty;
  assign mem_rsp_data  = rsp_head.data;
  assign mem_rsp_tag   = rsp_head.tag;

  always_comb begin
    outstanding_d = outstanding_q;
    if (rd_fire && !rsp_pop) outstanding_d = outstanding_q + 1'b1;
    else if (!rd_fire && rsp_pop) outstanding_d = outstanding_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_q <= '0;
      oob_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      if (req_fire && oob) oob_q <= 1'b1;
    end
  end

  assign tb_addr_out_of_bounds = oob_q;

  // Credits cover both the read pipeline and the FIFO.
  credit_cover: assert property (@(posedge clk) disable iff (reset) rsp_count <= outstanding_q);

`ifdef VX_LOCAL_MEM_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_reads        <= '0;
      perf_writes       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (rd_fire) perf_reads <= perf_reads + 1'b1;
      if (wr_fire) perf_writes <= perf_writes + 1'b1;
      if (mem_req_valid && !mem_req_ready) perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_local_mem_ctrl.sv
// Self-checking bench for vx_local_mem_ctrl: directed table, credit/reset sequences, random traffic.
module tb_vx_local_mem_ctrl;
  import vx_local_mem_pkg::*;

  localparam int unsigned WORDS = 4096;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = VX_MEM_DATA_WIDTH;
  localparam int unsigned BW    = VX_MEM_BYTEEN_WIDTH;
  localparam int unsigned AW    = VX_MEM_ADDR_WIDTH;
  localparam int unsigned TW    = VX_MEM_TAG_WIDTH;
  localparam int unsigned IW    = $clog2(WORDS);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req_valid = 1'b0;
  logic          mem_req_rw = 1'b0;
  logic [BW-1:0] mem_req_byteen = '0;
  logic [AW-1:0] mem_req_addr = '0;
  logic [DW-1:0] mem_req_data = '0;
  logic [TW-1:0] mem_req_tag = '0;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          mem_rsp_ready = 1'b0;
  logic          tb_addr_out_of_bounds;
`ifdef VX_LOCAL_MEM_PERF_EN
  logic [31:0]   perf_reads, perf_writes, perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  vx_local_mem_ctrl #(
    .MEM_WORDS (WORDS),
    .LATENCY   (LAT),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .mem_req_valid         (mem_req_valid),
    .mem_req_rw            (mem_req_rw),
    .mem_req_byteen        (mem_req_byteen),
    .mem_req_addr          (mem_req_addr),
    .mem_req_data          (mem_req_data),
    .mem_req_tag           (mem_req_tag),
    .mem_req_ready         (mem_req_ready),
    .mem_rsp_valid         (mem_rsp_valid),
    .mem_rsp_data          (mem_rsp_data),
    .mem_rsp_tag           (mem_rsp_tag),
    .mem_rsp_ready         (mem_rsp_ready),
`ifdef VX_LOCAL_MEM_PERF_EN
    .perf_reads            (perf_reads),
    .perf_writes           (perf_writes),
    .perf_stall_cycles     (perf_stall_cycles),
`endif
    .tb_addr_out_of_bounds (tb_addr_out_of_bounds)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit exp_flag = 1'b0;

  // Reference model: a plain word array and a queue of reads awaiting delivery.
  logic [DW-1:0] ref_mem [WORDS];
  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    int            due;
  } exp_rsp_t;
  exp_rsp_t exp_q[$];

  bit            last_acc, last_pop;
  logic [TW-1:0] seen_tag;
  logic [DW-1:0] seen_data;

  typedef struct {
    bit            rw;
    logic [AW-1:0] addr;
    logic [BW-1:0] byteen;
    logic [7:0]    wbyte;
    logic [TW-1:0] tag;
    logic [7:0]    exp_b0;
    logic [7:0]    exp_rest;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit rw, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d, input logic [TW-1:0] t);
    mem_req_valid  = v;
    mem_req_rw     = rw;
    mem_req_addr   = a;
    mem_req_byteen = be;
    mem_req_data   = d;
    mem_req_tag    = t;
  endtask

  // One clock: compare at negedge against the model, then advance the model at posedge.
  task automatic step();
    bit mv, mr, oob;
    exp_rsp_t e;
    logic [IW-1:0] ix;
    @(negedge clk);
    mr = exp_q.size() < DEPTH;
    mv = (exp_q.size() != 0) && (exp_q[0].due <= cyc);
    check("req_ready", DW'(mem_req_ready), DW'(mr));
    check("rsp_valid", DW'(mem_rsp_valid), DW'(mv));
    if (mv) begin
      check("rsp_data", mem_rsp_data, exp_q[0].data);
      check("rsp_tag", DW'(mem_rsp_tag), DW'(exp_q[0].tag));
    end
    check("oob_flag", DW'(tb_addr_out_of_bounds), DW'(exp_flag));
    last_acc  = mem_req_valid && mr;
    last_pop  = mv && mem_rsp_ready;
    seen_tag  = mem_rsp_tag;
    seen_data = mem_rsp_data;
    @(posedge clk);
    cyc++;
    if (last_pop) e = exp_q.pop_front();
    if (last_acc) begin
      oob = mem_req_addr >= AW'(WORDS);
      ix  = mem_req_addr[IW-1:0];
      if (oob) exp_flag = 1'b1;
      if (mem_req_rw) begin
        if (!oob)
          for (int i = 0; i < BW; i++)
            if (mem_req_byteen[i]) ref_mem[ix][i*8 +: 8] = mem_req_data[i*8 +: 8];
      end else begin
        e.tag  = mem_req_tag;
        e.data = oob ? '0 : ref_mem[ix];
        e.due  = cyc + LAT;
        exp_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic step_until_acc(input string name);
    int k = 0;
    do begin step(); k++; end while (!last_acc && k < 20);
    check(name, DW'(last_acc), DW'(1));
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat;
    logic [TW-1:0] want_tag;

    vecs[0] = '{1'b1, AW'('h10),  '1,      8'hA5, TW'(0), 8'h00, 8'h00};
    vecs[1] = '{1'b0, AW'('h10),  '0,      8'h00, TW'(3), 8'hA5, 8'hA5};
    vecs[2] = '{1'b1, AW'('h10),  BW'(1),  8'h5A, TW'(0), 8'h00, 8'h00};
    vecs[3] = '{1'b0, AW'('h10),  '0,      8'h00, TW'(4), 8'h5A, 8'hA5};
    vecs[4] = '{1'b1, AW'(0),     '1,      8'h11, TW'(0), 8'h00, 8'h00};
    vecs[5] = '{1'b0, AW'(WORDS), '0,      8'h00, TW'(5), 8'h00, 8'h00};
    vecs[6] = '{1'b1, AW'(WORDS), '1,      8'hFF, TW'(0), 8'h00, 8'h00};
    vecs[7] = '{1'b0, AW'(0),     '0,      8'h00, TW'(6), 8'h11, 8'h11};

    // Reset state.
    repeat (2) begin
      @(negedge clk);
      check("rst_req_ready", DW'(mem_req_ready), DW'(0));
      check("rst_rsp_valid", DW'(mem_rsp_valid), DW'(0));
      check("rst_rsp_data", mem_rsp_data, '0);
      check("rst_rsp_tag", DW'(mem_rsp_tag), DW'(0));
      check("rst_flag", DW'(tb_addr_out_of_bounds), DW'(0));
    end
    @(posedge clk);
    #1 reset = 1'b0;
    mem_rsp_ready = 1'b1;

    // Directed table.
    for (int v = 0; v < 8; v++) begin
      drive(1'b1, vecs[v].rw, vecs[v].addr, vecs[v].byteen, {BW{vecs[v].wbyte}}, vecs[v].tag);
      step_until_acc("vec_accept");
      drive(1'b0, 1'b0, '0, '0, '0, '0);
      if (!vecs[v].rw) begin
        lat = 0;
        do begin step(); lat++; end while (!last_pop && lat < 20);
        check("vec_latency", DW'(lat), DW'(LAT + 1));
        check("vec_data", seen_data, {{(BW-1){vecs[v].exp_rest}}, vecs[v].exp_b0});
        check("vec_tag", DW'(seen_tag), DW'(vecs[v].tag));
      end
    end
    check("flag_sticky", DW'(tb_addr_out_of_bounds), DW'(1));

    // Credit exhaustion: five reads with responses held back.
    mem_rsp_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      drive(1'b1, 1'b0, AW'('h10), '0, '0, TW'(n));
      step();
      if (last_acc) n++;
    end
    drive(1'b1, 1'b0, AW'('h10), '0, '0, TW'(4));
    repeat (4) begin
      step();
      if (last_acc) n++;
    end
    check("credit_stall_count", DW'(n), DW'(4));
    mem_rsp_ready = 1'b1;
    step();
    check("full_pop_no_accept", DW'(last_acc), DW'(0));
    check("first_pop_tag", DW'(seen_tag), DW'(0));
    mem_rsp_ready = 1'b0;
    step();
    check("fifth_accept", DW'(last_acc), DW'(1));
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    mem_rsp_ready = 1'b1;
    want_tag = TW'(1);
    for (int k = 0; k < 20 && want_tag <= TW'(4); k++) begin
      step();
      if (last_pop) begin
        check("order_tag", DW'(seen_tag), DW'(want_tag));
        want_tag = want_tag + 1'b1;
      end
    end
    check("drain_done", DW'(want_tag), DW'(5));

    // Accept and pop together with three outstanding.
    mem_rsp_ready = 1'b0;
    for (int t = 8; t < 11; t++) begin
      drive(1'b1, 1'b0, AW'('h10), '0, '0, TW'(t));
      step_until_acc("pre3_accept");
    end
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    repeat (3) step();
    drive(1'b1, 1'b0, AW'('h10), '0, '0, TW'(11));
    mem_rsp_ready = 1'b1;
    step();
    check("acc_pop_acc", DW'(last_acc), DW'(1));
    check("acc_pop_pop", DW'(last_pop), DW'(1));
    drive(1'b1, 1'b0, AW'('h10), '0, '0, TW'(12));
    mem_rsp_ready = 1'b0;
    step();
    check("acc_pop_ready_kept", DW'(last_acc), DW'(1));
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    mem_rsp_ready = 1'b1;
    repeat (10) step();

    // Reset with two reads in flight.
    for (int t = 20; t < 22; t++) begin
      drive(1'b1, 1'b0, AW'('h10), '0, '0, TW'(t));
      step_until_acc("inflight_accept");
    end
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    reset = 1'b1;
    exp_q.delete();
    exp_flag = 1'b0;
    @(negedge clk);
    check("midrst_ready", DW'(mem_req_ready), DW'(0));
    check("midrst_valid", DW'(mem_rsp_valid), DW'(0));
    check("midrst_data", mem_rsp_data, '0);
    check("midrst_tag", DW'(mem_rsp_tag), DW'(0));
    check("midrst_flag", DW'(tb_addr_out_of_bounds), DW'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) step();

    // Random traffic over a small initialised window plus out-of-range addresses.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, AW'(i), '1, rand_word(), '0);
      step_until_acc("init_accept");
    end
    for (int k = 0; k < 400; k++) begin
      int a;
      a = $urandom_range(0, 19);
      drive(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
            (a < 16) ? AW'(a) : AW'(WORDS + $urandom_range(0, 255)),
            {$urandom, $urandom}, rand_word(), TW'($urandom));
      mem_rsp_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    mem_rsp_ready = 1'b1;
    repeat (12) step();
    check("final_drained", DW'(exp_q.size()), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
